imem_fetch_responder: RTL

- Instruction-memory responder for the program counter's fetch requests: accepts a PC address, returns the 32-bit instruction word one cycle later.
- Sits between the PC register and the decode stage.
- Flags misaligned and out-of-range addresses as faults.
- Supports a redirect flush driven by the same PCsrc that selects PCtarget.
- Has a program-load port so the bench or a boot block can fill memory before execution.

---
 rtl/imem_fetch_if.sv | 23 ++
 rtl/imem_fetch_responder.sv | 85 ++++++++
 2 files changed

// File: rtl/imem_fetch_if.sv
// Fetch request/response bundle between the PC, the instruction memory responder and decode.
// Handshake: a transfer happens on a rising edge where valid && ready are both high; valid never waits on ready, and a valid payload stays stable until it transfers.
interface imem_fetch_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_fault;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction memory with a one-cycle fetch response, fault flagging, redirect flush
// and a program-load port that is only open while fetching is stopped.
module imem_fetch_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  imem_fetch_if.slave fetch,
  output logic        dbg_state
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state, state_next;
  logic [31:0] mem [DEPTH_WORDS];
  logic        accept;
  logic        req_ok;

  // Offset is formed in 33 bits so a window ending at 2^32 cannot wrap.
  function automatic logic word_ok(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a[1:0] == 2'b00) && !off[32] && (off < 33'(DEPTH_WORDS * 4));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  if (!load_en) state_next = S_RUN;
      S_RUN:   if (load_en)  state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  assign dbg_state       = (state == S_RUN);
  assign fetch.req_ready = (state == S_RUN) && (!fetch.rsp_valid || fetch.rsp_ready);
  assign accept          = fetch.req_valid && fetch.req_ready && !fetch.flush;
  assign req_ok          = word_ok(fetch.req_addr);

  // Contents are deliberately not reset; software loads them before running.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && load_en && load_we && word_ok(load_addr))
      mem[word_idx(load_addr)] <= load_data;
  end

  // Leaving RUN outranks flush, which outranks a new accept, which outranks completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch.rsp_valid <= 1'b0;
      fetch.rsp_instr <= NOP_INSTR;
      fetch.rsp_addr  <= 32'h0;
      fetch.rsp_fault <= 1'b0;
    end else if ((state == S_RUN) && load_en) begin
      fetch.rsp_valid <= 1'b0;
    end else if (fetch.flush) begin
      if (fetch.rsp_valid) begin
        fetch.rsp_valid <= 1'b0;
        fetch.rsp_instr <= NOP_INSTR;
      end
    end else if (accept) begin
      fetch.rsp_valid <= 1'b1;
      fetch.rsp_addr  <= fetch.req_addr;
      fetch.rsp_fault <= !req_ok;
      fetch.rsp_instr <= req_ok ? mem[word_idx(fetch.req_addr)] : NOP_INSTR;
    end else if (fetch.rsp_valid && fetch.rsp_ready) begin
      fetch.rsp_valid <= 1'b0;
    end
  end
endmodule
